multicycle_control_unit: RTL
============================

# multicycle_control_unit

Finite-state control unit for the multi-cycle MIPS datapath. It supersedes the single-cycle combinational decoder, which produced every control signal in the same cycle from `op`, `func` and `zero`. This block sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on a ready handshake from a variable-latency memory. It also adds a memory timeout, illegal-instruction reporting, a parametrised extended-ALU instruction mode, and a retired-instruction counter.

## Interface
Parameters:
- `EXT_EN`, 1: decode the extended group (addi, andi, ori, xori, add, sub, subu, sltu, and, nor, xor, sllv, sra, srav, srl, srlv). When 0, that group is illegal.
- `TIMEOUT`, 16: maximum cycles waiting on `mem_ready` before abort. Valid range 2..255.
- `CNT_W`, 32: width of `inst_count`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op` in 6: IR[31:26], held by the datapath's instruction register.
- `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, valid in EXEC.
- `mem_ready` in 1: memory completes the current access this cycle.
- `MemEn` out 1: memory request.
- `IorD` out 1: 0 selects PC as address, 1 selects ALUOut.
- `IRWrite` out 1: load the instruction register.
- `PCWrite` out 1: load PC.
- `PCSrc` out 2: 00 ALU result (PC+4); 01 jump target (see `JSrc`); 10 ALUOut (branch target).
- `JSrc` out 1: 1 selects rs (jr), 0 selects {PC[31:28], index, 00}.
- `ALUSrcA` out 2: 00 PC; 01 rs; 10 shamt.
- `ALUSrcB` out 2: 00 rt; 01 const 4; 10 sign-extended imm; 11 imm<<2 (zero-extended imm for andi/ori/xori uses 10 with `ZeroExt`).
- `ZeroExt` out 1: immediate is zero-extended.
- `ALUop` out 4: operation code from the package.
- `RegDst` out 2: 00 rt; 01 rd; 10 r31.
- `MemToReg` out 1: write-back selects memory data.
- `RegWrite` out 4: byte write enables, all 4'hF or 4'h0.
- `MemWrite` out 4: byte write enables, all 4'hF or 4'h0.
- `inst_done` out 1: one-cycle pulse when an instruction retires.
- `illegal` out 1: one-cycle pulse when an illegal op/func is detected.
- `mem_err` out 1: one-cycle pulse when a memory access times out.
- `inst_count` out CNT_W: number of retired instructions.

## Operation
- All outputs except `inst_count` are combinational from state, the latched `op`/`func`, `zero` and `mem_ready`. While `rst` is high, all outputs are 0.
- FETCH:
  - Drive `MemEn`=1 and `IorD`=0.
  - On `mem_ready`: drive `IRWrite`=1 and `PCWrite`=1 with PCSrc=00, ALUSrcA=00, ALUSrcB=01, ALUop=ADD. Go to DECODE.
- DECODE:
  - Drive ALUSrcA=00, ALUSrcB=11, ALUop=ADD, so ALUOut receives the branch target.
  - j: `PCWrite` with PCSrc=01, then go to FETCH and retire.
  - jal: same as j, plus `RegWrite` with RegDst=10, ALUSrcA=00, ALUSrcB=00, ALUop=PASSA, writing PC+4. There is no delay slot.
  - jr: `PCWrite` with PCSrc=01 and `JSrc`=1, then retire.
  - Illegal encoding: pulse `illegal`, go to FETCH, no retire, no writes.
  - Otherwise go to EXEC.
- EXEC:
  - beq/bne: ALUSrcA=01, ALUSrcB=00, ALUop=SUB. Assert `PCWrite` with PCSrc=10 iff (beq & zero) | (bne & ~zero). Retire.
  - lw/sw: ALUSrcA=01, ALUSrcB=10, ALUop=ADD. Go to MEM.
  - R-type and immediate ALU instructions: operands and ALUop per instruction. sll/sra/srl use ALUSrcA=10; lui uses ALUop=LUI. Go to WB.
- MEM:
  - Drive `MemEn`=1 and `IorD`=1. For sw, `MemWrite`=4'hF.
  - On `mem_ready`: lw goes to WB; sw retires.
- WB:
  - `RegWrite`=4'hF.
  - RegDst=01 for R-type, 00 otherwise.
  - `MemToReg`=1 only for lw.
  - Retire.
- Retire: `inst_done` pulses, `inst_count` increments, wrapping from 2^CNT_W−1 to 0, and the FSM goes to FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on `mem_ready`.
  - Increments each waiting cycle.
  - When it reaches TIMEOUT−1 without ready: pulse `mem_err`, drop `MemEn`/`MemWrite` that cycle, go to FETCH. No retire, no PC/IR/register write.
  - `mem_ready` arriving in the timeout cycle wins: the access completes and no error is raised.
- `mem_ready` outside FETCH/MEM is ignored.

## Timing
- Reset state: FETCH, wait counter 0, `inst_count` 0. Outputs 0 during reset.
- First `MemEn` appears in the first cycle after `rst` falls.
- Cycle counts with zero wait (`mem_ready` in the first cycle of FETCH/MEM):
  - j/jal/jr: 2.
  - Branch: 3.
  - sw: 4.
  - ALU instructions: 4.
  - lw: 5.
- Each wait cycle adds 1.
- Asserting `rst` mid-instruction aborts immediately. Partial effects are not replayed.

## Structure
- Package `mcu_pkg` holds:
  - State enum (FETCH, DECODE, EXEC, MEM, WB).
  - Opcode and funct constants.
  - ALUop codes: AND 0000, OR 0001, ADD 0010, LUI 0011, SLTU 0100, SLL 0101, SUB 0110, SLT 0111, NOR 1000, XOR 1001, SRL 1010, SRA 1011, PASSA 1100.
  - PCSrc, ALUSrc and RegDst select codes.
- Sub-module `mcu_decode` is combinational. It takes `op`, `func` and `EXT_EN`, and returns the instruction class (JUMP, BRANCH, LOAD, STORE, ALU_R, ALU_I, ILLEGAL), the ALUop, and the operand selects.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 constantly, IR=addu $3,$1,$2 → states FETCH, DECODE, EXEC, WB. `RegWrite`=4'hF and RegDst=01 in cycle 4. `inst_done` in cycle 4. `inst_count`=1.
- lw with `mem_ready` delayed 3 cycles in MEM → 8 cycles total. `MemToReg`=1 in WB. No `mem_err`.
- beq with `zero`=1 → `PCWrite` and PCSrc=10 in EXEC. With `zero`=0 → no `PCWrite`. bne gives the inverse.
- `mem_ready` held at 0 in FETCH with TIMEOUT=16 → `mem_err` pulses on wait cycle 16. Returns to FETCH. `inst_count` unchanged.
- EXT_EN=0 with xor, or any op=6'b111111 under either setting → `illegal` pulse in DECODE. No writes.
- `inst_count` preloaded near wrap with CNT_W=4 and 17 retires → count reads 1.
- Async `rst` asserted mid-MEM of sw → `MemWrite` drops the same cycle. Post-reset state is FETCH.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, instruction
// classes, opcode/funct values, ALU operation codes and datapath select codes.
package mcu_pkg;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

  typedef enum logic [2:0] {
    C_JUMP, C_BRANCH, C_LOAD, C_STORE, C_ALU_R, C_ALU_I, C_ILLEGAL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0011, ALU_SLTU = 4'b0100, ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR   = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001, ALU_SRL = 4'b1010, ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_PASSA = 4'b1100;

  localparam logic [1:0] PC_SEQ = 2'b00, PC_JUMP = 2'b01, PC_ALUOUT = 2'b10;
  localparam logic [1:0] SA_PC = 2'b00, SA_RS = 2'b01, SA_SHAMT = 2'b10;
  localparam logic [1:0] SB_RT = 2'b00, SB_FOUR = 2'b01, SB_IMM = 2'b10, SB_IMM_SH2 = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_R31 = 2'b10;

  typedef struct packed {
    iclass_e    cls;
    logic [3:0] aluop;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       zext;
    logic       link;
    logic       jreg;
    logic       bne;
  } dec_t;

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder: classifies op/func and picks the EXEC-stage
// ALU operation and operand selects. Extended-group encodings are illegal when EXT_EN=0.
module mcu_decode import mcu_pkg::*; #(
  parameter bit EXT_EN = 1'b1
) (
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output dec_t       o_dec
);

  logic w_ext;

  always_comb begin
    w_ext       = 1'b0;
    o_dec       = '0;
    o_dec.cls   = C_ILLEGAL;
    o_dec.aluop = ALU_ADD;
    o_dec.src_a = SA_RS;
    o_dec.src_b = SB_RT;
    case (i_op)
      OP_RTYPE: begin
        o_dec.cls = C_ALU_R;
        case (i_func)
          FN_ADDU: o_dec.aluop = ALU_ADD;
          FN_OR:   o_dec.aluop = ALU_OR;
          FN_SLT:  o_dec.aluop = ALU_SLT;
          FN_SLL:  begin o_dec.aluop = ALU_SLL; o_dec.src_a = SA_SHAMT; end
          FN_JR:   begin o_dec.cls = C_JUMP; o_dec.jreg = 1'b1; end
          FN_ADD:  begin o_dec.aluop = ALU_ADD;  w_ext = 1'b1; end
          FN_SUB:  begin o_dec.aluop = ALU_SUB;  w_ext = 1'b1; end
          FN_SUBU: begin o_dec.aluop = ALU_SUB;  w_ext = 1'b1; end
          FN_SLTU: begin o_dec.aluop = ALU_SLTU; w_ext = 1'b1; end
          FN_AND:  begin o_dec.aluop = ALU_AND;  w_ext = 1'b1; end
          FN_NOR:  begin o_dec.aluop = ALU_NOR;  w_ext = 1'b1; end
          FN_XOR:  begin o_dec.aluop = ALU_XOR;  w_ext = 1'b1; end
          FN_SLLV: begin o_dec.aluop = ALU_SLL;  w_ext = 1'b1; end
          FN_SRLV: begin o_dec.aluop = ALU_SRL;  w_ext = 1'b1; end
          FN_SRAV: begin o_dec.aluop = ALU_SRA;  w_ext = 1'b1; end
          FN_SRL:  begin o_dec.aluop = ALU_SRL; o_dec.src_a = SA_SHAMT; w_ext = 1'b1; end
          FN_SRA:  begin o_dec.aluop = ALU_SRA; o_dec.src_a = SA_SHAMT; w_ext = 1'b1; end
          default: o_dec.cls = C_ILLEGAL;
        endcase
      end
      OP_J:     o_dec.cls = C_JUMP;
      OP_JAL:   begin o_dec.cls = C_JUMP; o_dec.link = 1'b1; end
      OP_BEQ:   begin o_dec.cls = C_BRANCH; o_dec.aluop = ALU_SUB; end
      OP_BNE:   begin o_dec.cls = C_BRANCH; o_dec.aluop = ALU_SUB; o_dec.bne = 1'b1; end
      OP_LW:    begin o_dec.cls = C_LOAD;  o_dec.src_b = SB_IMM; end
      OP_SW:    begin o_dec.cls = C_STORE; o_dec.src_b = SB_IMM; end
      OP_ADDIU: begin o_dec.cls = C_ALU_I; o_dec.src_b = SB_IMM; end
      OP_SLTI:  begin o_dec.cls = C_ALU_I; o_dec.src_b = SB_IMM; o_dec.aluop = ALU_SLT; end
      OP_LUI:   begin o_dec.cls = C_ALU_I; o_dec.src_b = SB_IMM; o_dec.aluop = ALU_LUI; end
      OP_ADDI:  begin o_dec.cls = C_ALU_I; o_dec.src_b = SB_IMM; w_ext = 1'b1; end
      OP_ANDI:  begin
        o_dec.cls = C_ALU_I; o_dec.src_b = SB_IMM; o_dec.aluop = ALU_AND;
        o_dec.zext = 1'b1; w_ext = 1'b1;
      end
      OP_ORI:   begin
        o_dec.cls = C_ALU_I; o_dec.src_b = SB_IMM; o_dec.aluop = ALU_OR;
        o_dec.zext = 1'b1; w_ext = 1'b1;
      end
      OP_XORI:  begin
        o_dec.cls = C_ALU_I; o_dec.src_b = SB_IMM; o_dec.aluop = ALU_XOR;
        o_dec.zext = 1'b1; w_ext = 1'b1;
      end
      default:  o_dec.cls = C_ILLEGAL;
    endcase
    if (w_ext && !EXT_EN) o_dec.cls = C_ILLEGAL;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with memory ready/timeout handling and retire counter.
// States: FETCH ifetch wait | DECODE jumps, illegal | EXEC alu/branch/addr | MEM data wait | WB reg write
module multicycle_control_unit import mcu_pkg::*; #(
  parameter bit EXT_EN  = 1'b1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             MemEn,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             JSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ZeroExt,
  output logic [3:0]       ALUop,
  output logic [1:0]       RegDst,
  output logic             MemToReg,
  output logic [3:0]       RegWrite,
  output logic [3:0]       MemWrite,
  output logic             inst_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e           r_state, w_next;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_count;
  dec_t             w_dec;
  logic             w_waiting, w_timeout;

  mcu_decode #(.EXT_EN(EXT_EN)) u_decode (
    .i_op   (op),
    .i_func (func),
    .o_dec  (w_dec)
  );

  assign w_waiting  = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout  = w_waiting && !mem_ready && (r_wait == TO_LAST);
  assign inst_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Any state change, completion or abort restarts the wait count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           r_wait <= '0;
    else if (w_next != r_state || mem_ready || w_timeout) r_wait <= '0;
    else if (w_waiting)                                r_wait <= r_wait + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_count <= '0;
    else if (inst_done) r_count <= r_count + 1'b1;
  end

  always_comb begin
    w_next    = r_state;
    MemEn     = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = PC_SEQ;
    JSrc      = 1'b0;
    ALUSrcA   = SA_PC;
    ALUSrcB   = SB_RT;
    ZeroExt   = 1'b0;
    ALUop     = ALU_AND;
    RegDst    = RD_RT;
    MemToReg  = 1'b0;
    RegWrite  = 4'h0;
    MemWrite  = 4'h0;
    inst_done = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          if (w_timeout) begin
            mem_err = 1'b1;
          end else begin
            MemEn = 1'b1;
            if (mem_ready) begin
              IRWrite = 1'b1;
              PCWrite = 1'b1;
              ALUSrcB = SB_FOUR;
              ALUop   = ALU_ADD;
              w_next  = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          ALUSrcB = SB_IMM_SH2;
          ALUop   = ALU_ADD;
          case (w_dec.cls)
            C_JUMP: begin
              PCWrite   = 1'b1;
              PCSrc     = PC_JUMP;
              JSrc      = w_dec.jreg;
              inst_done = 1'b1;
              w_next    = S_FETCH;
              if (w_dec.link) begin
                RegWrite = 4'hF;
                RegDst   = RD_R31;
                ALUSrcB  = SB_RT;
                ALUop    = ALU_PASSA;
              end
            end
            C_ILLEGAL: begin
              illegal = 1'b1;
              w_next  = S_FETCH;
            end
            default: w_next = S_EXEC;
          endcase
        end
        S_EXEC: begin
          ALUSrcA = w_dec.src_a;
          ALUSrcB = w_dec.src_b;
          ALUop   = w_dec.aluop;
          ZeroExt = w_dec.zext;
          case (w_dec.cls)
            C_BRANCH: begin
              if (zero ^ w_dec.bne) begin
                PCWrite = 1'b1;
                PCSrc   = PC_ALUOUT;
              end
              inst_done = 1'b1;
              w_next    = S_FETCH;
            end
            C_LOAD, C_STORE: w_next = S_MEM;
            default:         w_next = S_WB;
          endcase
        end
        S_MEM: begin
          if (w_timeout) begin
            mem_err = 1'b1;
            w_next  = S_FETCH;
          end else begin
            MemEn    = 1'b1;
            IorD     = 1'b1;
            MemWrite = (w_dec.cls == C_STORE) ? 4'hF : 4'h0;
            if (mem_ready) begin
              if (w_dec.cls == C_LOAD) begin
                w_next = S_WB;
              end else begin
                inst_done = 1'b1;
                w_next    = S_FETCH;
              end
            end
          end
        end
        S_WB: begin
          RegWrite  = 4'hF;
          RegDst    = (w_dec.cls == C_ALU_R) ? RD_RD : RD_RT;
          MemToReg  = (w_dec.cls == C_LOAD);
          inst_done = 1'b1;
          w_next    = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule
